// File: rtl/cbus_rr_arbiter.sv
// N-way CBus arbiter, fixed-priority or round-robin, grant locked until the last beat.
// Grant visible 1 cycle after request; non-selected masters see ready=0; one idle bubble between bursts.
package cbus_pkg;
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [3:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;
endpackage

module cbus_rr_arbiter
    import cbus_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int POLICY     = 1,
    parameter int IDX_W      = $clog2(NUM_INPUTS)
) (
    input  logic             clk,
    input  logic             reset,
    input  cbus_req_t        ireqs  [NUM_INPUTS],
    output cbus_resp_t       iresps [NUM_INPUTS],
    output cbus_req_t        oreq,
    input  cbus_resp_t       oresp,
    output logic             busy,
    output logic [IDX_W-1:0] grant_idx
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           fsm, fsm_nxt;
    logic [IDX_W-1:0] sel, sel_nxt;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] sel_inc;
    logic             found;
    int               scan_idx;

    // Scan wraps at NUM_INPUTS, not at 2^IDX_W, so odd input counts rotate fairly.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        scan_idx = 0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            scan_idx = (POLICY == 1) ? int'(rr_ptr) + k : k;
            if (scan_idx >= NUM_INPUTS) begin
                scan_idx = scan_idx - NUM_INPUTS;
            end
            if (!found && ireqs[scan_idx].valid) begin
                found = 1'b1;
                win   = IDX_W'(scan_idx);
            end
        end
    end

    assign sel_inc = (sel == IDX_W'(NUM_INPUTS - 1)) ? '0 : sel + IDX_W'(1);

    always_comb begin
        fsm_nxt    = fsm;
        sel_nxt    = sel;
        rr_ptr_nxt = rr_ptr;
        oreq       = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            iresps[i] = '0;
        end
        case (fsm)
            IDLE: begin
                if (found) begin
                    fsm_nxt = BUSY;
                    sel_nxt = win;
                end
            end
            BUSY: begin
                // Forwarded even if the grantee drops valid; only last releases the bus.
                oreq        = ireqs[sel];
                iresps[sel] = oresp;
                if (oresp.ready && oresp.last) begin
                    fsm_nxt = IDLE;
                    if (POLICY == 1) begin
                        rr_ptr_nxt = sel_inc;
                    end
                end
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm    <= IDLE;
            sel    <= '0;
            rr_ptr <= '0;
        end else begin
            fsm    <= fsm_nxt;
            sel    <= sel_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    assign busy      = (fsm == BUSY);
    assign grant_idx = sel;

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Bench for cbus_rr_arbiter: directed vector table, hand sequences, and random traffic
// against a transaction-level model on three configurations (4/RR, 4/fixed, 3/RR).
module tb_cbus_rr_arbiter;
    import cbus_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    cbus_req_t  ireqs  [4];
    cbus_req_t  ireqs3 [3];
    cbus_resp_t oresp;

    cbus_resp_t iresps_a [4];
    cbus_resp_t iresps_b [4];
    cbus_resp_t iresps_c [3];
    cbus_req_t  oreq_a, oreq_b, oreq_c;
    logic       busy_a, busy_b, busy_c;
    logic [1:0] gidx_a, gidx_b, gidx_c;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 3; i++) ireqs3[i] = ireqs[i];
    end

    cbus_rr_arbiter #(.NUM_INPUTS(4), .POLICY(1)) dut_a (
        .clk(clk), .reset(reset), .ireqs(ireqs), .iresps(iresps_a),
        .oreq(oreq_a), .oresp(oresp), .busy(busy_a), .grant_idx(gidx_a));

    cbus_rr_arbiter #(.NUM_INPUTS(4), .POLICY(0)) dut_b (
        .clk(clk), .reset(reset), .ireqs(ireqs), .iresps(iresps_b),
        .oreq(oreq_b), .oresp(oresp), .busy(busy_b), .grant_idx(gidx_b));

    cbus_rr_arbiter #(.NUM_INPUTS(3), .POLICY(1)) dut_c (
        .clk(clk), .reset(reset), .ireqs(ireqs3), .iresps(iresps_c),
        .oreq(oreq_c), .oresp(oresp), .busy(busy_c), .grant_idx(gidx_c));

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_inputs(input logic [3:0] vm, input logic rdy, input logic lst);
        for (int i = 0; i < 4; i++) begin
            ireqs[i]       = '0;
            ireqs[i].valid = vm[i];
            ireqs[i].addr  = 32'h1000 + 32'(i) * 32'h100;
            ireqs[i].len   = 4'd4;
            ireqs[i].data  = 32'hA0 + 32'(i);
        end
        oresp.ready = rdy;
        oresp.last  = lst;
        oresp.data  = 32'hCAFE0000;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_inputs(4'b0000, 1'b0, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // ---------------- vector table (dut_a: 4 inputs, round-robin) ----------------
    typedef struct {
        logic [3:0]  vm;
        logic        rdy;
        logic        lst;
        logic        busy;
        logic [1:0]  gidx;
        logic        ovld;
        logic [31:0] oaddr;
        logic [3:0]  rmask;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic [3:0] vm, input logic rdy, input logic lst, input logic b,
                       input logic [1:0] g, input logic ov, input logic [31:0] a, input logic [3:0] rm);
        vec_t v;
        v = '{vm, rdy, lst, b, g, ov, a, rm};
        tbl.push_back(v);
    endtask

    // ---------------- behavioural model ----------------
    int own   [3];
    int lastg [3];
    int nxt   [3];
    int mdl_n [3] = '{4, 4, 3};
    int mdl_p [3] = '{1, 0, 1};

    function automatic void mdl_reset();
        for (int k = 0; k < 3; k++) begin
            own[k] = -1; lastg[k] = 0; nxt[k] = 0;
        end
    endfunction

    function automatic void mdl_step(int k);
        int c;
        if (own[k] >= 0) begin
            if (oresp.ready && oresp.last) begin
                if (mdl_p[k] == 1) nxt[k] = (own[k] + 1) % mdl_n[k];
                own[k] = -1;
            end
        end else begin
            for (int j = 0; j < mdl_n[k]; j++) begin
                c = ((mdl_p[k] == 1 ? nxt[k] : 0) + j) % mdl_n[k];
                if (own[k] < 0 && ireqs[c].valid) begin
                    own[k]   = c;
                    lastg[k] = c;
                end
            end
        end
    endfunction

    function automatic cbus_req_t exp_req(int k);
        if (own[k] >= 0) return ireqs[own[k]];
        return '0;
    endfunction

    function automatic cbus_resp_t exp_resp(int k, int i);
        if (own[k] == i) return oresp;
        return '0;
    endfunction

    initial begin
        vec_t v;

        // Reset state, checked while reset is held before any clock edge
        reset = 1'b1;
        set_inputs(4'b1111, 1'b1, 1'b1);
        #1;
        chk("rst_busy_a", {127'b0, busy_a}, 128'd0);
        chk("rst_gidx_a", {126'b0, gidx_a}, 128'd0);
        chk("rst_oreq_a", {51'b0, oreq_a}, 128'd0);
        chk("rst_iresp_a0", {94'b0, iresps_a[0]}, 128'd0);
        chk("rst_busy_c", {127'b0, busy_c}, 128'd0);
        do_reset();

        // Rotation 0,1,2,3,0 with single beats; then a 4-beat burst on input 2;
        // then input 1 arriving during a burst on input 0.
        add(4'hF,1,1, 0,0,0,32'h0,    4'b0000);
        add(4'hF,1,1, 1,0,1,32'h1000, 4'b0001);
        add(4'hF,1,1, 0,0,0,32'h0,    4'b0000);
        add(4'hF,1,1, 1,1,1,32'h1100, 4'b0010);
        add(4'hF,1,1, 0,1,0,32'h0,    4'b0000);
        add(4'hF,1,1, 1,2,1,32'h1200, 4'b0100);
        add(4'hF,1,1, 0,2,0,32'h0,    4'b0000);
        add(4'hF,1,1, 1,3,1,32'h1300, 4'b1000);
        add(4'hF,1,1, 0,3,0,32'h0,    4'b0000);
        add(4'hF,1,1, 1,0,1,32'h1000, 4'b0001);
        add(4'h0,1,1, 0,0,0,32'h0,    4'b0000);
        add(4'h4,0,0, 0,0,0,32'h0,    4'b0000);
        add(4'h4,0,0, 1,2,1,32'h1200, 4'b0000);
        add(4'h4,1,0, 1,2,1,32'h1200, 4'b0100);
        add(4'h4,1,0, 1,2,1,32'h1200, 4'b0100);
        add(4'h4,1,0, 1,2,1,32'h1200, 4'b0100);
        add(4'h4,1,1, 1,2,1,32'h1200, 4'b0100);
        add(4'h0,0,0, 0,2,0,32'h0,    4'b0000);
        add(4'h1,0,0, 0,2,0,32'h0,    4'b0000);
        add(4'h3,1,0, 1,0,1,32'h1000, 4'b0001);
        add(4'h3,1,1, 1,0,1,32'h1000, 4'b0001);
        add(4'h2,0,0, 0,0,0,32'h0,    4'b0000);
        add(4'h2,0,0, 1,1,1,32'h1100, 4'b0000);
        add(4'h2,1,1, 1,1,1,32'h1100, 4'b0010);
        add(4'h0,0,0, 0,1,0,32'h0,    4'b0000);

        for (int r = 0; r < tbl.size(); r++) begin
            v = tbl[r];
            set_inputs(v.vm, v.rdy, v.lst);
            @(negedge clk);
            chk($sformatf("tbl%0d_busy", r),  {127'b0, busy_a}, {127'b0, v.busy});
            chk($sformatf("tbl%0d_gidx", r),  {126'b0, gidx_a}, {126'b0, v.gidx});
            chk($sformatf("tbl%0d_ovld", r),  {127'b0, oreq_a.valid}, {127'b0, v.ovld});
            chk($sformatf("tbl%0d_oaddr", r), {96'b0, oreq_a.addr}, {96'b0, v.oaddr});
            chk($sformatf("tbl%0d_rmask", r),
                {124'b0, iresps_a[3].ready, iresps_a[2].ready, iresps_a[1].ready, iresps_a[0].ready},
                {124'b0, v.rmask});
            @(posedge clk);
            #1;
        end

        // Fixed priority: inputs 1 and 3 always valid, input 1 always wins
        do_reset();
        set_inputs(4'b1010, 1'b1, 1'b1);
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            chk($sformatf("fp%0d_busy", c), {127'b0, busy_b}, {127'b0, (c % 2 == 1)});
            chk($sformatf("fp%0d_gidx", c), {126'b0, gidx_b}, (c == 0) ? 128'd0 : 128'd1);
            chk($sformatf("fp%0d_r3", c), {127'b0, iresps_b[3].ready}, 128'd0);
            @(posedge clk);
            #1;
        end

        // Async reset during beat 2 of a burst on input 0
        do_reset();
        set_inputs(4'b0001, 1'b0, 1'b0);
        @(posedge clk);
        #1 set_inputs(4'b0001, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("mid_busy_pre", {127'b0, busy_a}, 128'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_busy", {127'b0, busy_a}, 128'd0);
        chk("mid_ovld", {127'b0, oreq_a.valid}, 128'd0);
        chk("mid_r0", {94'b0, iresps_a[0]}, 128'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        set_inputs(4'b1000, 1'b0, 1'b0);
        @(negedge clk);
        chk("post_idle", {127'b0, busy_a}, 128'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("post_busy", {127'b0, busy_a}, 128'd1);
        chk("post_gidx", {126'b0, gidx_a}, 128'd3);
        chk("post_oaddr", {96'b0, oreq_a.addr}, 128'h1300);

        // Three inputs, round-robin: wrap after input 2 goes to 0
        do_reset();
        set_inputs(4'b0100, 1'b1, 1'b1);
        @(posedge clk);
        #1 set_inputs(4'b0011, 1'b1, 1'b1);
        @(negedge clk);
        chk("n3_gidx2", {126'b0, gidx_c}, 128'd2);
        chk("n3_busy2", {127'b0, busy_c}, 128'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("n3_idle", {127'b0, busy_c}, 128'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("n3_wrap_gidx", {126'b0, gidx_c}, 128'd0);
        chk("n3_wrap_busy", {127'b0, busy_c}, 128'd1);

        // Random traffic against the model on all three configurations
        do_reset();
        mdl_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                ireqs[i].valid    = 1'($urandom_range(0, 1));
                ireqs[i].is_write = 1'($urandom_range(0, 1));
                ireqs[i].size     = 3'($urandom_range(0, 7));
                ireqs[i].addr     = $urandom;
                ireqs[i].strobe   = 4'($urandom_range(0, 15));
                ireqs[i].data     = $urandom;
                ireqs[i].len      = 4'($urandom_range(0, 15));
            end
            oresp.ready = 1'($urandom_range(0, 1));
            oresp.last  = ($urandom_range(0, 2) == 0);
            oresp.data  = $urandom;
            @(negedge clk);
            chk("rnd_busy_a", {127'b0, busy_a}, {127'b0, own[0] >= 0});
            chk("rnd_gidx_a", {126'b0, gidx_a}, 128'(lastg[0]));
            chk("rnd_oreq_a", {51'b0, oreq_a}, {51'b0, exp_req(0)});
            for (int i = 0; i < 4; i++)
                chk($sformatf("rnd_iresp_a%0d", i), {94'b0, iresps_a[i]}, {94'b0, exp_resp(0, i)});
            chk("rnd_busy_b", {127'b0, busy_b}, {127'b0, own[1] >= 0});
            chk("rnd_gidx_b", {126'b0, gidx_b}, 128'(lastg[1]));
            chk("rnd_oreq_b", {51'b0, oreq_b}, {51'b0, exp_req(1)});
            for (int i = 0; i < 4; i++)
                chk($sformatf("rnd_iresp_b%0d", i), {94'b0, iresps_b[i]}, {94'b0, exp_resp(1, i)});
            chk("rnd_busy_c", {127'b0, busy_c}, {127'b0, own[2] >= 0});
            chk("rnd_gidx_c", {126'b0, gidx_c}, 128'(lastg[2]));
            chk("rnd_oreq_c", {51'b0, oreq_c}, {51'b0, exp_req(2)});
            for (int i = 0; i < 3; i++)
                chk($sformatf("rnd_iresp_c%0d", i), {94'b0, iresps_c[i]}, {94'b0, exp_resp(2, i)});
            @(posedge clk);
            for (int k = 0; k < 3; k++) mdl_step(k);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
